// File: rtl/noc_loopback_responder.sv
// Loopback NoC endpoint: buffers one whole packet from channel VC and echoes it to the
// sender with dest/src swapped. Define NOC_RESPONDER_STATS_EN to add saturating packet counters.
module noc_loopback_responder #(
    parameter int NOC_FLIT_DATA_WIDTH = 32,
    parameter int NOC_FLIT_TYPE_WIDTH = 2,
    parameter int VCHANNELS           = 3,
    parameter int VC                  = 0,
    parameter int ID                  = 1,
    parameter int BUF_DEPTH           = 16
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [NOC_FLIT_TYPE_WIDTH+NOC_FLIT_DATA_WIDTH-1:0] rx_flit,
    input  logic [VCHANNELS-1:0]                              rx_valid,
    output logic [VCHANNELS-1:0]                              rx_ready,
    output logic [NOC_FLIT_TYPE_WIDTH+NOC_FLIT_DATA_WIDTH-1:0] tx_flit,
    output logic [VCHANNELS-1:0]                              tx_valid,
    input  logic [VCHANNELS-1:0]                              tx_ready,
    output logic                                              drop_err,
`ifdef NOC_RESPONDER_STATS_EN
    output logic [15:0]                                       stat_rx_pkts,
    output logic [15:0]                                       stat_tx_pkts,
    output logic [15:0]                                       stat_drops,
`endif
    output logic                                              busy
);

    localparam int DW = NOC_FLIT_DATA_WIDTH;
    localparam int TW = NOC_FLIT_TYPE_WIDTH;
    localparam int FW = TW + DW;
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [TW-1:0] TYPE_HEADER  = TW'(2'b01);
    localparam logic [TW-1:0] TYPE_LAST    = TW'(2'b10);
    localparam logic [TW-1:0] TYPE_SINGLE  = TW'(2'b11);

    typedef enum logic [1:0] {RECV_IDLE, RECV, DROP, SEND} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] wptr, wptr_nx;
    logic [PW-1:0] rptr, rptr_nx;
    logic [PW-1:0] len, len_nx;
    logic          drop_nx;
    logic          ready_en;
    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    logic [FW-1:0] pkt_mem [BUF_DEPTH];
    logic [FW-1:0] rd_flit;
    logic          rx_ready_vc;
    logic          tx_valid_vc;
    logic          rx_take;
    logic [TW-1:0] rx_type;

    // Only the serviced channel's handshake bits matter; the rest are sunk.
    logic unused_chan;
    assign unused_chan = ^{rx_valid, tx_ready};

    assign rx_ready_vc = ready_en && (state != SEND);
    assign tx_valid_vc = (state == SEND);
    assign rx_take     = rx_valid[VC] && rx_ready_vc;
    assign rx_type     = rx_flit[FW-1:DW];
    assign rd_flit     = pkt_mem[rptr[AW-1:0]];
    assign busy        = (state != RECV_IDLE);

    // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nx  = state;
        wptr_nx   = wptr;
        rptr_nx   = rptr;
        len_nx    = len;
        drop_nx   = 1'b0;
        buf_we    = 1'b0;
        buf_waddr = wptr[AW-1:0];
        case (state)
            RECV_IDLE: begin
                if (rx_take) begin
                    if (rx_type == TYPE_HEADER) begin
                        buf_we    = 1'b1;
                        buf_waddr = '0;
                        wptr_nx   = PW'(1);
                        state_nx  = RECV;
                    end else if (rx_type == TYPE_SINGLE) begin
                        buf_we    = 1'b1;
                        buf_waddr = '0;
                        len_nx    = PW'(1);
                        state_nx  = SEND;
                    end else begin
                        drop_nx = 1'b1;
                    end
                end
            end
            RECV: begin
                if (rx_take) begin
                    if (wptr == PW'(BUF_DEPTH)) begin
                        // An overflowing LAST closes the packet at once; anything else drains in DROP.
                        wptr_nx  = '0;
                        drop_nx  = (rx_type == TYPE_LAST);
                        state_nx = (rx_type == TYPE_LAST) ? RECV_IDLE : DROP;
                    end else begin
                        buf_we  = 1'b1;
                        wptr_nx = wptr + PW'(1);
                        if (rx_type == TYPE_LAST) begin
                            len_nx   = wptr + PW'(1);
                            wptr_nx  = '0;
                            state_nx = SEND;
                        end
                    end
                end
            end
            DROP: begin
                if (rx_take && rx_type == TYPE_LAST) begin
                    drop_nx  = 1'b1;
                    state_nx = RECV_IDLE;
                end
            end
            SEND: begin
                if (tx_ready[VC]) begin
                    if (rptr == len - PW'(1)) begin
                        rptr_nx  = '0;
                        state_nx = RECV_IDLE;
                    end else begin
                        rptr_nx = rptr + PW'(1);
                    end
                end
            end
            default: state_nx = RECV_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RECV_IDLE;
            wptr     <= '0;
            rptr     <= '0;
            len      <= '0;
            drop_err <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nx;
            wptr     <= wptr_nx;
            rptr     <= rptr_nx;
            len      <= len_nx;
            drop_err <= drop_nx;
            ready_en <= 1'b1;
        end
    end

    // NOTE: the packet buffer has no reset; entries are always written before the SEND state reads them.
    always_ff @(posedge clk) begin
        if (buf_we) pkt_mem[buf_waddr] <= rx_flit;
    end

    always_comb begin
        rx_ready     = {VCHANNELS{ready_en}};
        rx_ready[VC] = rx_ready_vc;
        tx_valid     = '0;
        tx_valid[VC] = tx_valid_vc;
        tx_flit      = '0;
        if (state == SEND) begin
            tx_flit = rd_flit;
            // Header rewrite: dest <- stored src, src <- own ID, class and low bits kept.
            if (rptr == '0)
                tx_flit[DW-1:0] = {rd_flit[23:19], rd_flit[26:24], 5'(ID), rd_flit[18:0]};
        end
    end

`ifdef NOC_RESPONDER_STATS_EN
    logic rx_done, tx_done;
    assign rx_done = (state != SEND) && (state_nx == SEND);
    assign tx_done = (state == SEND) && (state_nx == RECV_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rx_pkts <= '0;
            stat_tx_pkts <= '0;
            stat_drops   <= '0;
        end else begin
            if (rx_done && stat_rx_pkts != 16'hFFFF) stat_rx_pkts <= stat_rx_pkts + 16'd1;
            if (tx_done && stat_tx_pkts != 16'hFFFF) stat_tx_pkts <= stat_tx_pkts + 16'd1;
            if (drop_nx && stat_drops != 16'hFFFF)   stat_drops   <= stat_drops + 16'd1;
        end
    end
`endif

endmodule
